// File: rtl/uibi_pkg.sv
// rtl/uibi_pkg.sv - shared widths, FSM state type and error data for the UIBI arbiter
package uibi_pkg;

  localparam int XLEN        = 32;
  localparam int SLAVE_WIDTH = 2;
  localparam int AWIDTH      = XLEN - SLAVE_WIDTH;

  // Returned to a master when its target slave does not exist or times out
  localparam logic [XLEN-1:0] UIBI_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } uibi_state_e;

endpackage

// File: rtl/uibi_if.sv
// rtl/uibi_if.sv - UIBI master-side and slave-side bus bundle with environment/arbiter modports
interface uibi_if
  import uibi_pkg::*;
#(
  parameter int NMASTER = 2,
  parameter int NSLAVE  = 4
) ();

  // Master side
  logic [NMASTER-1:0][XLEN-1:0]        master_dat_o;
  logic [NMASTER-1:0][XLEN-1:0]        master_dat_i;
  logic [NMASTER-1:0][AWIDTH-1:0]      master_addr;
  logic [NMASTER-1:0][SLAVE_WIDTH-1:0] master_num;
  logic [NMASTER-1:0]                  master_req;
  logic [NMASTER-1:0]                  master_wen;
  logic [NMASTER-1:0][2:0]             master_mode;
  logic [NMASTER-1:0]                  master_ready;

  // Slave side
  logic [NSLAVE-1:0][XLEN-1:0]         slave_dat_i;
  logic [NSLAVE-1:0][XLEN-1:0]         slave_dat_o;
  logic [NSLAVE-1:0][AWIDTH-1:0]       slave_addr;
  logic [NSLAVE-1:0]                   slave_req;
  logic [NSLAVE-1:0]                   slave_wen;
  logic [NSLAVE-1:0][2:0]              slave_mode;
  logic [NSLAVE-1:0]                   slave_ready;

  // Environment view: masters issue requests, slaves answer them
  modport master (
    output master_dat_o, master_addr, master_num, master_req, master_wen, master_mode,
    input  master_dat_i, master_ready,
    input  slave_dat_i, slave_addr, slave_req, slave_wen, slave_mode,
    output slave_dat_o, slave_ready
  );

  // Arbiter view: answers masters, drives slaves
  modport slave (
    input  master_dat_o, master_addr, master_num, master_req, master_wen, master_mode,
    output master_dat_i, master_ready,
    output slave_dat_i, slave_addr, slave_req, slave_wen, slave_mode,
    input  slave_dat_o, slave_ready
  );

endinterface

// File: rtl/uibi_rr_arbiter.sv
// rtl/uibi_rr_arbiter.sv - combinational round-robin picker starting after last_grant
module uibi_rr_arbiter #(
  parameter int NMASTER = 2,
  parameter int IDXW    = (NMASTER > 1) ? $clog2(NMASTER) : 1
) (
  input  logic [NMASTER-1:0] req,
  input  logic [IDXW-1:0]    last_grant,
  output logic [IDXW-1:0]    grant,
  output logic               valid
);

  int idx;

  // Walk from farthest to nearest so the requester closest after last_grant wins
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = NMASTER; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NMASTER;
      if (req[idx]) begin
        grant = idx[IDXW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uibi_arbiter.sv
// rtl/uibi_arbiter.sv - N-master to M-slave UIBI arbiter, one transaction in flight; optional UIBI_TIMEOUT_EN slave wait limit
module uibi_arbiter
  import uibi_pkg::*;
#(
  parameter int NMASTER = 2,
  parameter int NSLAVE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic   clk,
  input  logic   rst_n,
  uibi_if.slave  bus
);

  localparam int IDXW = (NMASTER > 1) ? $clog2(NMASTER) : 1;

  uibi_state_e            state, state_nxt;
  logic [IDXW-1:0]        pick, grant_q, last_grant_q;
  logic                   pick_valid, pick_err, slave_hit, wait_expired;
  logic [AWIDTH-1:0]      addr_q;
  logic [SLAVE_WIDTH-1:0] num_q;
  logic                   wen_q;
  logic [2:0]             mode_q;
  logic [XLEN-1:0]        wdat_q, rdat_q;

  uibi_rr_arbiter #(.NMASTER(NMASTER), .IDXW(IDXW)) u_rr (
    .req        (bus.master_req),
    .last_grant (last_grant_q),
    .grant      (pick),
    .valid      (pick_valid)
  );

  assign pick_err  = (int'(bus.master_num[pick]) >= NSLAVE);
  assign slave_hit = (state == ST_BUSY) && bus.slave_ready[num_q];

`ifdef UIBI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Count BUSY cycles; held at zero elsewhere so each transaction starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt <= '0;
    else if (state != ST_BUSY)  wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + CW'(1);
  end

  assign wait_expired = (state == ST_BUSY) && !bus.slave_ready[num_q] &&
                        (wait_cnt == CW'(TIMEOUT - 1));
`else
  assign wait_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: nonexistent slaves bypass BUSY and answer with error data
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_valid) state_nxt = pick_err ? ST_RESP : ST_BUSY;
      ST_BUSY: if (slave_hit || wait_expired) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Transaction capture at grant, response capture at slave completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      last_grant_q <= IDXW'(NMASTER - 1);
      addr_q       <= '0;
      num_q        <= '0;
      wen_q        <= 1'b0;
      mode_q       <= '0;
      wdat_q       <= '0;
      rdat_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick;
            addr_q  <= bus.master_addr[pick];
            num_q   <= bus.master_num[pick];
            wen_q   <= bus.master_wen[pick];
            mode_q  <= bus.master_mode[pick];
            wdat_q  <= bus.master_dat_o[pick];
            rdat_q  <= pick_err ? UIBI_ERR_DATA : '0;
          end
        end
        ST_BUSY: begin
          if (slave_hit)         rdat_q <= wen_q ? '0 : bus.slave_dat_o[num_q];
          else if (wait_expired) rdat_q <= UIBI_ERR_DATA;
        end
        ST_RESP: last_grant_q <= grant_q;
        default: ;
      endcase
    end
  end

  // Bus outputs decoded from state so reset clears them without waiting for a clock
  always_comb begin
    bus.slave_req    = '0;
    bus.slave_wen    = '0;
    bus.slave_mode   = '0;
    bus.slave_addr   = '0;
    bus.slave_dat_i  = '0;
    bus.master_ready = '0;
    bus.master_dat_i = '0;
    if (state == ST_BUSY) begin
      bus.slave_req[num_q]   = 1'b1;
      bus.slave_wen[num_q]   = wen_q;
      bus.slave_mode[num_q]  = mode_q;
      bus.slave_addr[num_q]  = addr_q;
      bus.slave_dat_i[num_q] = wdat_q;
    end
    if (state == ST_RESP) begin
      bus.master_ready[grant_q] = 1'b1;
      bus.master_dat_i[grant_q] = rdat_q;
    end
  end

endmodule

// File: tb/tb_uibi_arbiter.sv
// tb/tb_uibi_arbiter.sv - directed-vector bench for uibi_arbiter (2 masters, 3 slaves, TIMEOUT=4)
module tb_uibi_arbiter;

  logic clk;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;

  uibi_if #(.NMASTER(2), .NSLAVE(3)) bus ();

  uibi_arbiter #(.NMASTER(2), .NSLAVE(3), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int grants[$];
  logic [31:0] gdat[$];

  initial begin
    rst_n = 1'b0;
    bus.master_dat_o = '0;
    bus.master_addr  = '0;
    bus.master_num   = '0;
    bus.master_req   = '0;
    bus.master_wen   = '0;
    bus.master_mode  = '0;
    bus.slave_dat_o  = '0;
    bus.slave_ready  = '0;

    tick();
    tick();
    chk("rst_master_ready", 32'(bus.master_ready), 32'h0);
    chk("rst_slave_req",    32'(bus.slave_req),    32'h0);
    chk("rst_dat_i0",       bus.master_dat_i[0],   32'h0);
    rst_n = 1'b1;
    tick();

    // Master 0 read of slave 1, zero wait
    bus.master_req[0]  = 1'b1;
    bus.master_num[0]  = 2'd1;
    bus.master_wen[0]  = 1'b0;
    bus.master_mode[0] = 3'b111;
    bus.master_addr[0] = 30'h5;
    chk("t1_c0_ready", 32'(bus.master_ready), 32'h0);
    tick();
    chk("t1_c1_slave_req",  32'(bus.slave_req),   32'h2);
    chk("t1_c1_slave_addr", 32'(bus.slave_addr[1]), 32'h5);
    chk("t1_c1_slave_mode", 32'(bus.slave_mode[1]), 32'h7);
    chk("t1_c1_ready",      32'(bus.master_ready), 32'h0);
    bus.master_req[0]  = 1'b0;
    bus.master_num[0]  = 2'd0;
    bus.slave_ready[1] = 1'b1;
    bus.slave_dat_o[1] = 32'h1234_5678;
    tick();
    chk("t1_c2_slave_req", 32'(bus.slave_req),    32'h0);
    chk("t1_c2_ready",     32'(bus.master_ready), 32'h1);
    chk("t1_c2_dat0",      bus.master_dat_i[0],   32'h1234_5678);
    chk("t1_c2_dat1",      bus.master_dat_i[1],   32'h0);
    bus.slave_ready[1] = 1'b0;
    tick();
    chk("t1_c3_ready", 32'(bus.master_ready), 32'h0);
    chk("t1_c3_dat0",  bus.master_dat_i[0],   32'h0);

    // Master 1 byte write to slave 2, slave waits 3 cycles
    bus.master_req[1]    = 1'b1;
    bus.master_num[1]    = 2'd2;
    bus.master_wen[1]    = 1'b1;
    bus.master_mode[1]   = 3'b001;
    bus.master_dat_o[1]  = 32'hAB;
    tick();
    chk("t2_c1_slave_req",  32'(bus.slave_req),      32'h4);
    chk("t2_c1_slave_wen",  32'(bus.slave_wen[2]),   32'h1);
    chk("t2_c1_slave_mode", 32'(bus.slave_mode[2]),  32'h1);
    chk("t2_c1_slave_dat",  bus.slave_dat_i[2],      32'hAB);
    chk("t2_c1_other_dat",  bus.slave_dat_i[1],      32'h0);
    bus.master_req[1] = 1'b0;
    tick();
    chk("t2_c2_slave_req", 32'(bus.slave_req), 32'h4);
    bus.slave_ready[0] = 1'b1;
    tick();
    chk("t2_c3_slave_req", 32'(bus.slave_req),    32'h4);
    chk("t2_c3_ready",     32'(bus.master_ready), 32'h0);
    bus.slave_ready[0] = 1'b0;
    tick();
    chk("t2_c4_ready", 32'(bus.master_ready), 32'h0);
    bus.slave_ready[2] = 1'b1;
    bus.slave_dat_o[2] = 32'hFFFF_FFFF;
    tick();
    chk("t2_c5_ready",     32'(bus.master_ready), 32'h2);
    chk("t2_c5_dat1",      bus.master_dat_i[1],   32'h0);
    chk("t2_c5_slave_req", 32'(bus.slave_req),    32'h0);
    bus.slave_ready[2] = 1'b0;
    bus.master_wen[1]  = 1'b0;
    tick();

    // Nonexistent slave 3
    bus.master_req[0] = 1'b1;
    bus.master_num[0] = 2'd3;
    tick();
    chk("t3_c1_ready",     32'(bus.master_ready), 32'h1);
    chk("t3_c1_dat0",      bus.master_dat_i[0],   32'hDEAD_BEEF);
    chk("t3_c1_slave_req", 32'(bus.slave_req),    32'h0);
    bus.master_req[0] = 1'b0;
    bus.master_num[0] = 2'd1;
    tick();
    chk("t3_c2_ready", 32'(bus.master_ready), 32'h0);

    // Slave 1 never ready
    bus.master_req[0] = 1'b1;
    tick();
    bus.master_req[0] = 1'b0;
`ifdef UIBI_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("to_c%0d_slave_req", c), 32'(bus.slave_req), 32'h2);
      if (c < 4) tick();
    end
    tick();
    chk("to_c5_slave_req", 32'(bus.slave_req),    32'h0);
    chk("to_c5_ready",     32'(bus.master_ready), 32'h1);
    chk("to_c5_dat0",      bus.master_dat_i[0],   32'hDEAD_BEEF);
    tick();
`else
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("wait_c%0d_slave_req", c), 32'(bus.slave_req), 32'h2);
      tick();
    end
    chk("wait_ready_none", 32'(bus.master_ready), 32'h0);
    bus.slave_ready[1] = 1'b1;
    bus.slave_dat_o[1] = 32'h55;
    tick();
    chk("wait_ready", 32'(bus.master_ready), 32'h1);
    chk("wait_dat0",  bus.master_dat_i[0],   32'h55);
    bus.slave_ready[1] = 1'b0;
    tick();
`endif

    // Reset during BUSY aborts; then master 0 has priority and grants alternate
    bus.master_req[1] = 1'b1;
    bus.master_num[1] = 2'd1;
    tick();
    chk("rb_busy_slave_req", 32'(bus.slave_req), 32'h2);
    bus.master_req[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rb_async_slave_req", 32'(bus.slave_req),    32'h0);
    chk("rb_async_ready",     32'(bus.master_ready), 32'h0);
    tick();
    chk("rb_held_ready", 32'(bus.master_ready), 32'h0);
    rst_n = 1'b1;
    bus.master_req     = 2'b11;
    bus.master_num[0]  = 2'd0;
    bus.master_num[1]  = 2'd1;
    bus.slave_ready    = 3'b011;
    bus.slave_dat_o[0] = 32'hA0;
    bus.slave_dat_o[1] = 32'hB1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) chk("rr_first_slave_req", 32'(bus.slave_req), 32'h1);
      if (bus.master_ready != 2'b00) begin
        grants.push_back(bus.master_ready[1] ? 1 : 0);
        gdat.push_back(bus.master_ready[1] ? bus.master_dat_i[1] : bus.master_dat_i[0]);
      end
    end
    chk("rr_grant_count", 32'(grants.size()), 32'd4);
    foreach (grants[i]) begin
      chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
      chk($sformatf("rr_dat%0d", i), gdat[i], (i % 2) ? 32'hB1 : 32'hA0);
    end
    bus.master_req  = '0;
    bus.slave_ready = '0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uibi_arbiter.md
UIBI_ARBITER -- requirements
Module: uibi_arbiter

Interface
REQ-001 SHALL have parameter NMASTER, default 2, number of UIBI master ports (2..8).
REQ-002 SHALL have parameter NSLAVE, default 4, number of populated slave ports (1..2^SLAVE_WIDTH).
REQ-003 SHALL have parameter TIMEOUT, default 255, slave wait-cycle limit (used only under UIBI_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port master_dat_o  input  [NMASTER][XLEN]  write data from masters.
REQ-007 SHALL have port master_dat_i  output  [NMASTER][XLEN]  read data to masters.
REQ-008 SHALL have port master_addr  input  [NMASTER][XLEN-SLAVE_WIDTH]  in-slave address.
REQ-009 SHALL have port master_num  input  [NMASTER][SLAVE_WIDTH]  target slave index.
REQ-010 SHALL have ports master_req, master_wen  input  [NMASTER]  request level, write enable.
REQ-011 SHALL have port master_mode  input  [NMASTER][3]  byte mode (111 word, 011 half, 001 byte).
REQ-012 SHALL have port master_ready  output  [NMASTER]  one-cycle completion pulse.
REQ-013 SHALL have ports slave_dat_i, slave_addr, slave_req, slave_wen, slave_mode  output  [NSLAVE][...]  widths as master side.
REQ-014 SHALL have ports slave_dat_o  input  [NSLAVE][XLEN] and slave_ready  input  [NSLAVE].

Function
REQ-015 SHALL run FSM IDLE -> BUSY -> RESP -> IDLE; one transaction outstanding at a time.
REQ-016 IDLE: if any master_req, SHALL grant round-robin starting at last_grant+1 (mod NMASTER), latch that master's addr/num/wen/mode/dat, go BUSY next edge.
REQ-017 BUSY: SHALL drive slave_req[num]=1 plus latched fields on slave[num] only; all other slave outputs zero.
REQ-018 BUSY: on slave_ready[num]=1 SHALL latch slave_dat_o[num] (reads) or 0 (writes), go RESP.
REQ-019 RESP: SHALL drive master_ready[grant]=1 and master_dat_i[grant]=latched data for exactly one cycle, update last_grant=grant, go IDLE.
REQ-020 master_dat_i of non-granted masters and outside RESP SHALL be zero.
REQ-021 Latency: req sampled at edge 0, slave_req high from edge 1; zero-wait slave (ready in cycle 1) -> master_ready in cycle 2; k-cycle slave wait -> master_ready at cycle 2+k.
REQ-022 slave_req SHALL fall at the edge after slave_ready is sampled; slave_ready outside BUSY or from non-addressed slave SHALL be ignored.
REQ-023 num >= NSLAVE: SHALL skip BUSY, go RESP with data 32'hDEAD_BEEF, no slave_req asserted.
REQ-024 master_req changes after grant SHALL not affect the latched transaction.
REQ-025 Master held req after ready SHALL be treated as a new request in the following IDLE cycle, subject to round-robin.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, all master_ready/slave_req/data outputs 0, last_grant=NMASTER-1 (master 0 first priority).
REQ-027 Reset mid-BUSY SHALL abort the transaction with no master_ready pulse.

Configuration
REQ-028 With UIBI_TIMEOUT_EN defined, a wait counter SHALL clear on entering BUSY, increment each BUSY cycle, and on reaching TIMEOUT without slave_ready force RESP with data 32'hDEAD_BEEF and drop slave_req.
REQ-029 Without UIBI_TIMEOUT_EN, no counter SHALL exist and BUSY SHALL wait indefinitely.

Structure
REQ-030 Package uibi_pkg SHALL hold XLEN, SLAVE_WIDTH, FSM state enum, UIBI_ERR_DATA=32'hDEAD_BEEF.
REQ-031 Sub-module uibi_rr_arbiter SHALL implement the combinational round-robin picker (req vector, last_grant in; grant index, valid out).

Verification
REQ-032 Master0 read, slave 1 zero-wait, slave_dat_o=32'h1234_5678 -> slave_req[1] cycle 1, master_ready[0] and master_dat_i[0]=32'h1234_5678 in cycle 2.
REQ-033 Masters 0 and 1 request simultaneously and continuously -> grants alternate 0,1,0,1 after reset.
REQ-034 Master1 write, num=2, mode=001, dat=32'hAB, slave waits 3 cycles -> slave_wen[2]=1, slave_mode[2]=001, master_ready[1] cycle 5, data 0.
REQ-035 num=3 with NSLAVE=3 -> no slave_req, master_ready cycle 1 with data 32'hDEAD_BEEF.
REQ-036 rst_n low during BUSY -> slave_req and master_ready 0 immediately; after release master 0 wins.
REQ-037 UIBI_TIMEOUT_EN, TIMEOUT=4, slave never ready -> slave_req drops after 4 BUSY cycles, master_ready with 32'hDEAD_BEEF.
